// File: rtl/fpu_addsub_arbiter_pkg.sv
// Shared types and constants for the addsub arbiter slice.
package fpu_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] QNAN_H = 16'h7E00;
    localparam logic        OP_ADD = 1'b0;
    localparam logic        OP_SUB = 1'b1;
endpackage

// File: rtl/fpu_addsub_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % N_REQ]) begin
                any = 1'b1;
                idx = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one half-precision addsub unit between N_REQ requesters, one op in flight,
// with a watchdog that turns a missing completion into a qNaN error response.
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ-1:0]    req_opcode,
    input  logic [16*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [15:0]         rsp_data,
    output logic                rsp_err,
    output logic                fu_start,
    output logic                fu_opcode,
    output logic [15:0]         fu_a,
    output logic [15:0]         fu_b,
    input  logic [15:0]         fu_out,
    input  logic                fu_done,
    output logic                busy,
    output logic [15:0]         op_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gidx;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] g;
    logic             any;
    logic [WD_W-1:0]  wdog;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g),
        .any   (any)
    );

    // Gated by rst_n so the accept strobe is quiet while reset is held.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            fu_start  <= 1'b0;
            fu_opcode <= 1'b0;
            fu_a      <= '0;
            fu_b      <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            wdog      <= '0;
            op_count  <= '0;
        end else begin
            fu_start <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    gidx      <= g;
                    fu_opcode <= req_opcode[g];
                    fu_a      <= req_a[16*g +: 16];
                    fu_b      <= req_b[16*g +: 16];
                    rr_ptr    <= (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
                    fu_start  <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the expiry cycle still counts as a good result.
                    if (fu_done) begin
                        rsp_data <= fu_out;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        rsp_data <= QNAN_H;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: if (rsp_ready[gidx]) begin
                    op_count <= op_count + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: behavioural addsub stand-in with programmable latency,
// round-robin/scoreboard model, scenario tasks plus a randomized run.
module tb_fpu_addsub_arbiter;
    localparam int N  = 4;
    localparam int TO = 63;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid, req_ready, req_opcode, rsp_valid, rsp_ready;
    logic [16*N-1:0] req_a, req_b;
    logic [15:0]   rsp_data, fu_a, fu_b, fu_out, op_count;
    logic          rsp_err, fu_start, fu_opcode, fu_done, busy;

    fpu_addsub_arbiter #(.N_REQ(N), .IDX_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fu_start(fu_start), .fu_opcode(fu_opcode), .fu_a(fu_a), .fu_b(fu_b),
        .fu_out(fu_out), .fu_done(fu_done), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int model_ptr = 0, model_count = 0;
    int fu_lat = 3;
    bit stub_never = 0, late_pulse = 0;
    int cnt = 0, cyc = 0, starts = 0, run = 0, maxrun = 0, start_cyc = 0;
    logic [15:0] la, lb, seen_a, seen_b;
    logic        lop, seen_op;

    // Known half-precision results; other operand pairs get an arbitrary but deterministic value.
    function automatic logic [15:0] fu_ref(input logic op, input logic [15:0] a, input logic [15:0] b);
        case ({op, a, b})
            {1'b0, 16'h3C00, 16'h3C00}: return 16'h4000;
            {1'b1, 16'h4000, 16'h3C00}: return 16'h3C00;
            {1'b1, 16'h3C00, 16'h3C00}: return 16'h0000;
            {1'b0, 16'h7C00, 16'h3C00}: return 16'h7C00;
            {1'b0, 16'hC000, 16'h4000}: return 16'h0000;
            default: return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]} ^ {15'd0, op};
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // addsub stand-in plus fu_start pulse monitor
    initial begin
        fu_done = 1'b0;
        fu_out  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fu_start) begin
                run++;
                if (run == 1) begin starts++; start_cyc = cyc; end
                if (run > maxrun) maxrun = run;
            end else run = 0;
            fu_done = 1'b0;
            if (!rst_n) cnt = 0;
            else begin
                if (late_pulse) begin fu_done = 1'b1; fu_out = 16'hBEEF; late_pulse = 0; end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin fu_done = 1'b1; fu_out = fu_ref(lop, la, lb); end
                end
                if (fu_start && run == 1) begin
                    seen_a = fu_a; seen_b = fu_b; seen_op = fu_opcode;
                    if (!stub_never) begin cnt = fu_lat; la = fu_a; lb = fu_b; lop = fu_opcode; end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
        req_valid[i] = 1'b1;
        req_opcode[i] = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // Drives one accept/response round; reports what was observed, judges nothing.
    task automatic serve_one(input bit drop, input int bp, output int g, output int rv,
                             output logic [15:0] d, output logic e, output int rc, output bit ok);
        int n;
        ok = 1; g = -1; rv = -1; d = '0; e = 1'b0; rc = 0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
        if (req_ready == '0) begin ok = 0; return; end
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        if ($countones(req_ready) != 1) g = -2;
        @(negedge clk);
        if (drop && g >= 0) req_valid[g] = 1'b0;
        n = 0;
        while (rsp_valid == '0 && n < 200) begin @(negedge clk); n++; end
        if (rsp_valid == '0) begin ok = 0; return; end
        rc = cyc;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) rv = i;
        if ($countones(rsp_valid) != 1) rv = -2;
        d = rsp_data;
        e = rsp_err;
        repeat (bp) @(negedge clk);
        rsp_ready = rsp_valid;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, fu_start, fu_opcode, fu_a, fu_b, busy, op_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req_ready=%b rsp_valid=%b rsp_data=%h busy=%b op_count=%h exp all 0",
                     req_ready, rsp_valid, rsp_data, busy, op_count);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, op_count} !== '0) begin
            failures++;
            $display("FAIL reset_release got busy=%b rsp_valid=%b op_count=%h exp 0", busy, rsp_valid, op_count);
        end
        model_ptr = 0; model_count = 0;
    endtask

    task automatic test_basic();
        int g, rv, rc, ge; logic [15:0] d; logic e; bit ok;
        logic [15:0] av [3] = '{16'h3C00, 16'h4000, 16'h3C00};
        logic [15:0] bv [3] = '{16'h3C00, 16'h3C00, 16'h3C00};
        logic [15:0] xv [3] = '{16'h4000, 16'h3C00, 16'h0000};
        int          iv [3] = '{0, 2, 1};
        logic        ov [3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            set_req(iv[k], ov[k], av[k], bv[k]);
            ge = pick(req_valid, model_ptr);
            serve_one(1, 0, g, rv, d, e, rc, ok);
            req_valid = '0;
            model_ptr = (ge + 1) % N; model_count++;
            checks++;
            if (!ok || g !== iv[k] || rv !== iv[k]) begin
                failures++;
                $display("FAIL basic_grant k=%0d got ok=%0d grant=%0d rsp_idx=%0d exp %0d", k, ok, g, rv, iv[k]);
            end
            checks++;
            if (d !== xv[k] || e !== 1'b0) begin
                failures++;
                $display("FAIL basic_data k=%0d got %h err=%b exp %h err=0", k, d, e, xv[k]);
            end
            checks++;
            if (op_count !== 16'(model_count) || seen_a !== av[k] || seen_b !== bv[k] || seen_op !== ov[k]) begin
                failures++;
                $display("FAIL basic_issue k=%0d got cnt=%0d a=%h b=%h op=%b exp cnt=%0d a=%h b=%h op=%b",
                         k, op_count, seen_a, seen_b, seen_op, model_count, av[k], bv[k], ov[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int g, rv, rc, s0; logic [15:0] d, x; logic e; bit ok;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        set_req(0, 1'b0, 16'h7C00, 16'h3C00);
        set_req(1, 1'b0, 16'h3C00, 16'h3C00);
        set_req(2, 1'b1, 16'h4000, 16'h3C00);
        set_req(3, 1'b1, 16'h3C00, 16'h3C00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = starts; maxrun = 0;
        for (int k = 0; k < 5; k++) begin
            serve_one(0, 0, g, rv, d, e, rc, ok);
            x = fu_ref(req_opcode[exp_g[k]], req_a[16*exp_g[k] +: 16], req_b[16*exp_g[k] +: 16]);
            checks++;
            if (!ok || g !== exp_g[k] || rv !== exp_g[k] || d !== x) begin
                failures++;
                $display("FAIL rr_order k=%0d got ok=%0d grant=%0d rsp_idx=%0d data=%h exp grant %0d data %h",
                         k, ok, g, rv, d, exp_g[k], x);
            end
            if (k == 0) begin
                checks++;
                if (d !== 16'h7C00) begin
                    failures++;
                    $display("FAIL rr_inf got %h exp 7c00", d);
                end
            end
        end
        req_valid = '0;
        checks++;
        if (starts - s0 != 5 || maxrun != 1) begin
            failures++;
            $display("FAIL rr_start_pulses got starts=%0d maxlen=%0d exp 5 and 1", starts - s0, maxrun);
        end
        model_ptr = 1; model_count = 5;
    endtask

    task automatic test_back_pressure();
        int g, rv, rc, n, s0, ge; logic [15:0] d, d0; logic e; bit ok;
        set_req(1, 1'b1, 16'h4000, 16'h3C00);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        set_req(0, 1'(($urandom & 1)), 16'($urandom), 16'($urandom));
        set_req(3, 1'(($urandom & 1)), 16'($urandom), 16'($urandom));
        n = 0;
        while (rsp_valid == '0 && n < 200) begin @(negedge clk); n++; end
        d0 = rsp_data;
        s0 = starts;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== d0 || req_ready !== '0) begin
                failures++;
                $display("FAIL bp_hold k=%0d got rsp_valid=%b data=%h req_ready=%b exp 0010 %h 0000",
                         k, rsp_valid, rsp_data, req_ready, d0);
            end
        end
        checks++;
        if (starts != s0 || d0 !== 16'h3C00) begin
            failures++;
            $display("FAIL bp_result got starts=%0d data=%h exp 0 new starts data 3c00", starts - s0, d0);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = '0;
        model_ptr = 2; model_count++;
        ge = pick(req_valid, model_ptr);
        serve_one(1, 0, g, rv, d, e, rc, ok);
        req_valid = '0;
        model_ptr = (ge + 1) % N; model_count++;
        checks++;
        if (!ok || g !== ge || d !== fu_ref(req_opcode[ge], req_a[16*ge +: 16], req_b[16*ge +: 16])
            || op_count !== 16'(model_count)) begin
            failures++;
            $display("FAIL bp_next got ok=%0d grant=%0d data=%h cnt=%0d exp grant %0d cnt %0d",
                     ok, g, d, op_count, ge, model_count);
        end
    endtask

    task automatic test_timeout();
        int g, rv, rc; logic [15:0] d; logic e; bit ok;
        stub_never = 1;
        set_req(0, 1'b0, 16'h3C00, 16'h4000);
        serve_one(1, 0, g, rv, d, e, rc, ok);
        req_valid = '0;
        model_ptr = 1; model_count++;
        checks++;
        if (!ok || d !== 16'h7E00 || e !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err got ok=%0d data=%h err=%b exp 7e00 err=1", ok, d, e);
        end
        checks++;
        if (rc - start_cyc < TO || rc - start_cyc > TO + 2) begin
            failures++;
            $display("FAIL timeout_len got %0d cycles exp about %0d", rc - start_cyc, TO + 1);
        end
        late_pulse = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || op_count !== 16'(model_count)) begin
            failures++;
            $display("FAIL late_done got busy=%b rsp_valid=%b cnt=%0d exp 0 0 %0d", busy, rsp_valid, op_count, model_count);
        end
        stub_never = 0;
        // completion on the expiry cycle wins; one cycle later does not
        for (int k = 0; k < 2; k++) begin
            fu_lat = TO + k;
            set_req(1, 1'b0, 16'h3C00, 16'h3C00);
            serve_one(1, 0, g, rv, d, e, rc, ok);
            req_valid = '0;
            model_ptr = 2; model_count++;
            repeat (3) @(negedge clk);
            checks++;
            if (!ok || d !== (k == 0 ? 16'h4000 : 16'h7E00) || e !== 1'(k)) begin
                failures++;
                $display("FAIL timeout_edge lat=%0d got ok=%0d data=%h err=%b exp %h err=%0d",
                         fu_lat, ok, d, e, (k == 0 ? 16'h4000 : 16'h7E00), k);
            end
        end
        fu_lat = 3;
    endtask

    task automatic test_random();
        int g, rv, rc, ge; logic [15:0] d, x; logic e; bit ok; logic [N-1:0] mask;
        for (int it = 0; it < 24; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) set_req(i, 1'($urandom & 1), 16'($urandom), 16'($urandom));
            fu_lat = $urandom_range(1, 8);
            ge = pick(mask, model_ptr);
            x = fu_ref(req_opcode[ge], req_a[16*ge +: 16], req_b[16*ge +: 16]);
            serve_one(1, $urandom_range(0, 3), g, rv, d, e, rc, ok);
            model_ptr = (ge + 1) % N; model_count++;
            checks++;
            if (!ok || g !== ge || rv !== ge || d !== x || e !== 1'b0) begin
                failures++;
                $display("FAIL rand it=%0d mask=%b got ok=%0d grant=%0d rsp_idx=%0d data=%h err=%b exp %0d %h",
                         it, mask, ok, g, rv, d, e, ge, x);
            end
            checks++;
            if (seen_a !== req_a[16*ge +: 16] || seen_b !== req_b[16*ge +: 16] || seen_op !== req_opcode[ge]
                || op_count !== 16'(model_count)) begin
                failures++;
                $display("FAIL rand_issue it=%0d got a=%h b=%h op=%b cnt=%0d exp a=%h b=%h op=%b cnt=%0d", it,
                         seen_a, seen_b, seen_op, op_count, req_a[16*ge +: 16], req_b[16*ge +: 16], req_opcode[ge], model_count);
            end
            req_valid = '0;
        end
        fu_lat = 3;
    endtask

    task automatic test_reset_mid();
        int g, rv, rc; logic [15:0] d; logic e; bit ok, seen;
        fu_lat = 20;
        set_req(model_ptr, 1'b0, 16'h3C00, 16'h3C00);
        #1;
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got %b exp 1", busy);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, fu_start, fu_opcode, fu_a, fu_b, busy, op_count} !== '0) begin
            failures++;
            $display("FAIL mid_reset got fu_a=%h fu_b=%h busy=%b op_count=%h exp all 0", fu_a, fu_b, busy, op_count);
        end
        rst_n = 1'b1;
        model_ptr = 0; model_count = 0;
        fu_lat = 3;
        seen = 0;
        repeat (25) begin @(negedge clk); if (rsp_valid != '0 || busy) seen = 1; end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_stale got a response or busy after reset exp idle");
        end
        set_req(1, 1'b0, 16'hC000, 16'h4000);
        set_req(2, 1'b1, 16'h1234, 16'h4321);
        serve_one(1, 0, g, rv, d, e, rc, ok);
        req_valid = '0;
        checks++;
        if (!ok || g !== 1 || rv !== 1 || d !== 16'h0000 || e !== 1'b0 || op_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_fresh got ok=%0d grant=%0d data=%h err=%b cnt=%0d exp 1 0000 0 1",
                     ok, g, d, e, op_count);
        end
    endtask

    initial begin
        req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_back_pressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_bound got no finish exp finish before time limit");
        $fatal(1);
    end
endmodule
